// File: rtl/reg_file_port.sv
// Two-read/one-write register file over byte addresses, register 0 hardwired
// to zero, with a one-register-per-cycle clear sequence and a sticky alignment flag.
module reg_file_port #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rs1_data,
  output logic [WORD_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]         cnt;
  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  logic [IW-1:0] rs1_idx;
  logic [IW-1:0] rs2_idx;
  logic [IW-1:0] wr_idx;
  logic          rs1_mis;
  logic          rs2_mis;
  logic          wr_mis;
  logic          idle;
  logic          clr_go;
  logic          rd_go;
  logic          wr_go;
  logic          wr_ok;
  logic          err_set;
  logic          cnt_done;

  logic [WORD_WIDTH-1:0] rs1_nx;
  logic [WORD_WIDTH-1:0] rs2_nx;

  assign rs1_idx = rs1_addr[IW+1:2];
  assign rs2_idx = rs2_addr[IW+1:2];
  assign wr_idx  = rd_addr[IW+1:2];
  assign rs1_mis = |rs1_addr[1:0];
  assign rs2_mis = |rs2_addr[1:0];
  assign wr_mis  = |rd_addr[1:0];

  // A clear request outranks any read or write presented on the same edge.
  assign idle     = (state == IDLE);
  assign clr_go   = idle & clr_req;
  assign rd_go    = idle & rd_req & ~clr_req;
  assign wr_go    = idle & wr_en & ~clr_req;
  assign wr_ok    = wr_go & ~wr_mis & (wr_idx != '0);
  assign err_set  = (rd_go & (rs1_mis | rs2_mis))
                  | (wr_go & wr_mis);
  assign cnt_done = (cnt == IW'(NUM_REGS - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) state_nx = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write-first: a same-edge write to the read index is forwarded.
  always_comb begin
    rs1_nx = '0;
    rs2_nx = '0;
    if (!rs1_mis) begin
      if (wr_ok && (wr_idx == rs1_idx)) rs1_nx = wr_data;
      else                              rs1_nx = regs[rs1_idx];
    end
    if (!rs2_mis) begin
      if (wr_ok && (wr_idx == rs2_idx)) rs2_nx = wr_data;
      else                              rs2_nx = regs[rs2_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) begin
        cnt <= cnt_done ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_ok) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rs1_data <= rs1_nx;
        rs2_data <= rs2_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (clr_go) begin
      addr_err <= 1'b0;
    end else if (err_set) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_port.sv
// Directed bench for reg_file_port: reads, writes, bypass, clear sequence,
// alignment errors and asynchronous reset aborts.
module tb_reg_file_port;

  localparam int WW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rd_req;
  logic          rd_valid;
  logic [WW-1:0] rs1_data;
  logic [WW-1:0] rs2_data;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [WW-1:0] wr_data;
  logic          clr_req;
  logic          busy;
  logic          addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  reg_file_port dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [WW-1:0] d);
    rd_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    rd_req   = 1'b1;
    tick();
    rd_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rd_req = 0; wr_en = 0; wr_data = '0; clr_req = 0;
    tick();
    tick();
    n_chk++;
    if ({rd_valid, busy, addr_err} !== 3'b000 ||
        rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: vld=%b busy=%b err=%b d1=%h d2=%h want all 0",
               rd_valid, busy, addr_err, rs1_data, rs2_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_write(7'h14, 32'hDEADBEEF);
    n_chk++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_novld: rd_valid=%b want 0", rd_valid);
    end
    do_read(7'h14, 7'h00);
    n_chk++;
    if (rd_valid !== 1'b1 || rs1_data !== 32'hDEADBEEF ||
        rs2_data !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_read: vld=%b d1=%h d2=%h want 1 deadbeef 0",
               rd_valid, rs1_data, rs2_data);
    end
    tick();
    n_chk++;
    if (rd_valid !== 1'b0 || rs1_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_hold: vld=%b d1=%h want 0 deadbeef",
               rd_valid, rs1_data);
    end
  endtask

  task automatic test_bypass();
    rd_addr  = 7'h7C;
    wr_data  = 32'h12345678;
    wr_en    = 1'b1;
    rs1_addr = 7'h7C;
    rs2_addr = 7'h14;
    rd_req   = 1'b1;
    tick();
    wr_en    = 1'b0;
    rd_req   = 1'b0;
    n_chk++;
    if (rd_valid !== 1'b1 || rs1_data !== 32'h12345678 ||
        rs2_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass: vld=%b d1=%h d2=%h want 1 12345678 deadbeef",
               rd_valid, rs1_data, rs2_data);
    end
    do_write(7'h00, 32'hFFFFFFFF);
    do_read(7'h00, 7'h7C);
    n_chk++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL reg0: d1=%h d2=%h want 0 12345678",
               rs1_data, rs2_data);
    end
  endtask

  task automatic test_misalign();
    do_write(7'h08, 32'h000000A5);
    n_chk++;
    if (addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_idle: addr_err=%b want 0", addr_err);
    end
    do_read(7'h16, 7'h08);
    n_chk++;
    if (addr_err !== 1'b1 || rd_valid !== 1'b1 ||
        rs1_data !== 32'h0 || rs2_data !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL mis_read: err=%b vld=%b d1=%h d2=%h want 1 1 0 a5",
               addr_err, rd_valid, rs1_data, rs2_data);
    end
    do_write(7'h09, 32'h00000077);
    do_read(7'h08, 7'h0C);
    n_chk++;
    if (rs1_data !== 32'h000000A5 || rs2_data !== 32'h0 ||
        addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_write: d1=%h d2=%h err=%b want a5 0 1",
               rs1_data, rs2_data, addr_err);
    end
  endtask

  task automatic test_clear();
    int cyc;
    for (int i = 1; i < 32; i++) do_write(AW'(i * 4), WW'(i));
    do_read(7'h7C, 7'h04);
    n_chk++;
    if (rs1_data !== 32'd31 || rs2_data !== 32'd1) begin
      n_fail++;
      $display("FAIL fill: d1=%h d2=%h want 1f 1", rs1_data, rs2_data);
    end
    clr_req  = 1'b1;
    rd_req   = 1'b1;
    rs1_addr = 7'h0C;
    rs2_addr = 7'h08;
    wr_en    = 1'b1;
    rd_addr  = 7'h0C;
    wr_data  = 32'hBAD0BAD0;
    tick();
    clr_req  = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_start: busy=%b vld=%b err=%b want 1 0 0",
               busy, rd_valid, addr_err);
    end
    cyc = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      clr_req = (k == 5);
      tick();
      if (busy === 1'b1) cyc++;
      n_chk++;
      if (rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_vld: k=%0d rd_valid=%b want 0", k, rd_valid);
      end
    end
    clr_req = 1'b0;
    rd_req  = 1'b0;
    wr_en   = 1'b0;
    n_chk++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL clr_len: busy cycles=%0d want 32", cyc);
    end
    for (int i = 0; i < 32; i += 2) begin
      do_read(AW'(i * 4), AW'(i * 4 + 4));
      n_chk++;
      if (rd_valid !== 1'b1 || rs1_data !== 32'h0 ||
          rs2_data !== 32'h0) begin
        n_fail++;
        $display("FAIL clr_zero: idx=%0d vld=%b d1=%h d2=%h want 1 0 0",
                 i, rd_valid, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_write(7'h10, 32'hCAFEF00D);
    do_read(7'h10, 7'h10);
    rst = 1'b1;
    #1;
    n_chk++;
    if (rd_valid !== 1'b0 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_read: vld=%b d1=%h d2=%h want 0 0 0",
               rd_valid, rs1_data, rs2_data);
    end
    tick();
    rst = 1'b0;
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || addr_err !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_clear: busy=%b err=%b vld=%b want 0 0 0",
               busy, addr_err, rd_valid);
    end
    tick();
    rst = 1'b0;
    do_write(7'h04, 32'h55AA55AA);
    do_read(7'h04, 7'h00);
    n_chk++;
    if (rd_valid !== 1'b1 || rs1_data !== 32'h55AA55AA ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: vld=%b d1=%h busy=%b want 1 55aa55aa 0",
               rd_valid, rs1_data, busy);
    end
    tick();
    n_chk++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after_vld: rd_valid=%b want 0", rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_misalign();
    test_clear();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_port.md
REG_FILE_PORT -- requirements
Module: reg_file_port

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data width of every register and data port.
REQ-002 Parameter ADDR_WIDTH, default 7, width of byte-address register selectors (0x00..0x7C).
REQ-003 Parameter NUM_REGS, default 32, number of architectural registers.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rs1_addr  input  ADDR_WIDTH  byte address of source register 1 (index*4).
REQ-007 rs2_addr  input  ADDR_WIDTH  byte address of source register 2.
REQ-008 rd_req  input  1  read request for rs1/rs2, sampled on rising edge.
REQ-009 rd_valid  output  1  one-cycle strobe; rs1_data/rs2_data valid.
REQ-010 rs1_data  output  WORD_WIDTH  registered read data for rs1.
REQ-011 rs2_data  output  WORD_WIDTH  registered read data for rs2.
REQ-012 rd_addr  input  ADDR_WIDTH  byte address of destination register.
REQ-013 wr_en  input  1  write strobe for rd_addr/wr_data.
REQ-014 wr_data  input  WORD_WIDTH  write data.
REQ-015 clr_req  input  1  request to zero all registers.
REQ-016 busy  output  1  high while the clear sequence runs.
REQ-017 addr_err  output  1  sticky misaligned-address flag.

Function
REQ-018 Register index shall be addr[6:2]; addr[1:0] shall be 00 for an aligned access.
REQ-019 Register 0 shall always read 0; writes to index 0 shall be discarded.
REQ-020 FSM states IDLE and CLEAR; IDLE + clr_req -> CLEAR; CLEAR -> IDLE after the counter zeroes index NUM_REGS-1.
REQ-021 CLEAR shall zero one register per cycle, counter 0..31, exactly 32 cycles with busy=1, busy=0 on first IDLE cycle.
REQ-022 clr_req during CLEAR shall be ignored (no restart).
REQ-023 In IDLE, rd_req at edge N shall give rd_valid=1 with data during cycle N+1 (1-cycle latency), rd_valid=0 otherwise.
REQ-024 rs1_data/rs2_data shall hold their last values when rd_valid=0.
REQ-025 In IDLE, wr_en at edge N shall update the register at edge N; the value is visible to rd_req sampled at edge N+1.
REQ-026 Simultaneous rd_req and wr_en to the same nonzero index shall return wr_data (write-first bypass).
REQ-027 rd_req and wr_en during CLEAR shall be ignored: no write, rd_valid stays 0.
REQ-028 A misaligned rs1_addr/rs2_addr with rd_req, or misaligned rd_addr with wr_en, in IDLE shall set addr_err at that edge.
REQ-029 A misaligned read operand shall return 0; a misaligned write shall be suppressed; the aligned operand of the same request is unaffected.
REQ-030 addr_err shall clear only on reset or on acceptance of clr_req (IDLE -> CLEAR edge).
REQ-031 clr_req with simultaneous wr_en or rd_req in IDLE: clear wins; write dropped, no rd_valid.

Reset
REQ-032 rst=1 shall immediately force state IDLE, counter 0, all registers 0, rd_valid=0, rs1_data=rs2_data=0, busy=0, addr_err=0.
REQ-033 rst asserted mid-CLEAR or mid-read shall abort the operation; first edge after rst deasserts is a normal IDLE cycle.

Verification
REQ-034 Write 0xDEADBEEF to rd_addr=0x14, next cycle rd_req rs1=0x14 rs2=0x00 -> rd_valid one cycle later, rs1_data=0xDEADBEEF, rs2_data=0.
REQ-035 Same edge wr_en rd_addr=0x7C data=0x12345678 and rd_req rs1=0x7C -> rs1_data=0x12345678; write to 0x00 then read 0x00 -> 0.
REQ-036 Fill regs 1..31 with index values, pulse clr_req -> busy high exactly 32 cycles, rd_req during busy gives no rd_valid, afterwards all reads return 0.
REQ-037 rd_req rs1=0x16 rs2=0x08 (reg2=0xA5) -> addr_err=1, rs1_data=0, rs2_data=0xA5; wr_en rd_addr=0x09 -> no register change; clr_req clears addr_err.
REQ-038 Assert rst at cycle 10 of CLEAR and during a pending read -> all outputs 0 immediately, busy=0, subsequent write/read of 0x04 works with 1-cycle latency.
